t05_keyentry: RTL

- Consumer end of the keypad path: takes the 5-bit key code and synchronized strobe produced by the keypad encoder/synchronizer and turns key presses into a multi-digit BCD entry.
- Detects press edges and enforces a release-debounce interval. Applies digit, backspace, clear and enter keys.
- Presents a committed value to downstream logic with a valid/ack handshake.

---
 rtl/t05_keyentry_if.sv | 24 ++
 rtl/t05_keyentry.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/t05_keyentry_if.sv
// Key-entry bus: encoder-side key code/strobe and downstream ack in,
// BCD entry buffer, committed-value flag and per-key pulses out.
interface t05_keyentry_if #(
  parameter int DIGITS = 4
);
  logic [4:0]          code;
  logic                strobe;
  logic                ack;
  logic [4*DIGITS-1:0] digits;
  logic [3:0]          count;
  logic                value_valid;
  logic                key_event;
  logic                overflow;

  modport master (
    output code, strobe, ack,
    input  digits, count, value_valid, key_event, overflow
  );

  modport slave (
    input  code, strobe, ack,
    output digits, count, value_valid, key_event, overflow
  );
endinterface

// File: rtl/t05_keyentry.sv
// Keypad entry consumer: press-edge detection with release debounce, BCD
// digit/backspace/clear/enter handling and a valid/ack commit handshake.
module t05_keyentry #(
  parameter int DIGITS         = 4,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic           clock,
  input  logic           reset,
  t05_keyentry_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] REL_MAX = CW'(RELEASE_CYCLES);
  localparam logic [3:0]    DIG_MAX = 4'(DIGITS);

  localparam logic [4:0] KEY_BACKSPACE = 5'd10;
  localparam logic [4:0] KEY_CLEAR     = 5'd11;
  localparam logic [4:0] KEY_ENTER     = 5'd12;

  typedef enum logic [1:0] {
    ENTRY,
    WAIT_RELEASE,
    COMMIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic          strobe_q, strobe_d;
  logic [W-1:0]  digits_q, digits_d;
  logic [3:0]    count_q, count_d;
  logic          value_valid_q, value_valid_d;
  logic          key_event_q, key_event_d;
  logic          overflow_q, overflow_d;

  logic          press;
  logic [CW-1:0] rel_inc;

  assign press   = bus.strobe & ~strobe_q;
  assign rel_inc = (rel_cnt_q == REL_MAX) ? REL_MAX : rel_cnt_q + CW'(1);

  always_comb begin
    // NOTE: every _d gets a default here so no path through the case leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    rel_cnt_d     = rel_cnt_q;
    strobe_d      = bus.strobe;
    digits_d      = digits_q;
    count_d       = count_q;
    value_valid_d = value_valid_q;
    key_event_d   = 1'b0;
    overflow_d    = 1'b0;

    unique case (state_q)
      ENTRY: begin
        if (press) begin
          state_d   = WAIT_RELEASE;
          rel_cnt_d = '0;
          if (bus.code < 5'd10) begin
            if (count_q < DIG_MAX) begin
              digits_d    = (digits_q << 4) | W'(bus.code[3:0]);
              count_d     = count_q + 4'd1;
              key_event_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (bus.code == KEY_BACKSPACE) begin
            if (count_q != 4'd0) begin
              digits_d    = digits_q >> 4;
              count_d     = count_q - 4'd1;
              key_event_d = 1'b1;
            end
          end else if (bus.code == KEY_CLEAR) begin
            digits_d    = '0;
            count_d     = 4'd0;
            key_event_d = 1'b1;
          end else if (bus.code == KEY_ENTER) begin
            if (count_q != 4'd0) begin
              key_event_d   = 1'b1;
              value_valid_d = 1'b1;
              state_d       = COMMIT;
            end
          end
        end
      end

      WAIT_RELEASE: begin
        // Any high strobe, including bounce re-edges, restarts the quiet run.
        if (bus.strobe) begin
          rel_cnt_d = '0;
        end else if (rel_inc == REL_MAX) begin
          rel_cnt_d = '0;
          state_d   = ENTRY;
        end else begin
          rel_cnt_d = rel_inc;
        end
      end

      COMMIT: begin
        if (bus.ack) begin
          value_valid_d = 1'b0;
          digits_d      = '0;
          count_d       = 4'd0;
          rel_cnt_d     = '0;
          state_d       = WAIT_RELEASE;
        end
      end

      default: state_d = WAIT_RELEASE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= WAIT_RELEASE;
      rel_cnt_q     <= '0;
      strobe_q      <= 1'b1;  // a key held through reset must be released first
      digits_q      <= '0;
      count_q       <= 4'd0;
      value_valid_q <= 1'b0;
      key_event_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rel_cnt_q     <= rel_cnt_d;
      strobe_q      <= strobe_d;
      digits_q      <= digits_d;
      count_q       <= count_d;
      value_valid_q <= value_valid_d;
      key_event_q   <= key_event_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.count       = count_q;
  assign bus.value_valid = value_valid_q;
  assign bus.key_event   = key_event_q;
  assign bus.overflow    = overflow_q;
endmodule
